ds_adc_avg_decim: RTL and testbench
===================================

// Module: ds_adc_avg_decim
// PURPOSE
//  Post-filter decimator downstream of the delta-sigma ADC digital stage.
//  Accepts signed WIDTH-bit ADC words on clk, sums blocks of 2**LOG2_N valid samples,
//  and emits the block mean on a valid/ready output port.
//  Used to further reduce sample rate and noise before register readout or the scoreboard.
// PARAMETERS
//  WIDTH   8  bit width of input samples and of the averaged output (signed, two's complement)
//  LOG2_N  4  log2 of block length; N = 2**LOG2_N samples per output; legal range 1..8
// PORTS
//  clk          in   1          system clock; all logic on rising edge
//  rst          in   1          synchronous reset, active-high
//  en           in   1          block enable; 0 = hold idle and discard the partial block
//  din_valid    in   1          din qualifies this cycle
//  din          in   WIDTH      signed ADC sample (dig_out of the ADC model)
//  avg_out      out  WIDTH      signed block mean
//  avg_valid    out  1          avg_out holds an unconsumed result
//  avg_ready    in   1          consumer accepts avg_out when avg_valid=1
//  overrun      out  1          sticky flag: a result was overwritten before consumption
//  clr_overrun  in   1          clear overrun (1-cycle pulse)
//  sample_cnt   out  LOG2_N     samples accumulated in the current block, 0..N-1
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, acc=0, sample_cnt=0, avg_out=0, avg_valid=0,
//    overrun=0. Reset wins over every other input, including mid-block and mid-handshake.
//  FSM states: IDLE, ACCUM.
//    IDLE -> ACCUM when en=1. ACCUM -> IDLE when en=0.
//    Entering IDLE clears acc and sample_cnt on the same edge. Any pending avg_out/avg_valid is kept.
//  Accumulator: acc is signed, WIDTH+LOG2_N bits wide. It never overflows for any input sequence.
//  Sample accept: in ACCUM with din_valid=1, acc += sext(din) and sample_cnt += 1.
//    din_valid is ignored in IDLE. The sample that arrives in the IDLE->ACCUM cycle is not counted.
//  Block end: the accept with sample_cnt==N-1 completes the block.
//    result = (acc + sext(din)) >>> LOG2_N. The shift is arithmetic, so results floor toward -inf.
//    result always fits WIDTH bits; no saturation logic.
//    On the same edge acc<=0 and sample_cnt<=0; the next valid sample starts a new block.
//  Latency: avg_out/avg_valid update on the edge that accepts the Nth sample,
//    visible the cycle after that sample is presented.
//  Output handshake: transfer occurs when avg_valid && avg_ready at posedge.
//    avg_out stays stable while avg_valid=1 and no transfer or new result occurs.
//    Transfer, no new result: avg_valid<=0 and avg_out holds its value.
//    New result, avg_valid=0: avg_out<=result, avg_valid<=1.
//    New result and transfer on the same edge: avg_out<=result, avg_valid stays 1, no overrun.
//    New result, avg_valid=1, avg_ready=0: avg_out<=result (newest kept), avg_valid stays 1,
//      overrun<=1.
//  overrun: set as above and cleared by clr_overrun. If set and clear occur on the same edge, set wins.
//  avg_ready is ignored when avg_valid=0. The block never stalls din; there is no input ready.
// TESTING
//  T1: en=1, 16 valid samples of +5, avg_ready=1 -> one avg_valid pulse, avg_out=5,
//      sample_cnt back to 0.
//  T2: alternating +3/-4 x16 -> sum=-8, avg_out=-1 (floor). 16 x -1 -> avg_out=-1.
//      16 x 127 -> 127. 16 x -128 -> -128.
//  T3: avg_ready=0, 32 samples of +2 then 16 of +7 -> avg_out=7, avg_valid=1, overrun=1.
//      Then clr_overrun with no new result -> overrun=0.
//  T4: 16th sample accepted on the same edge avg_ready=1 consumes the prior result
//      -> avg_valid stays 1, new value shown, overrun=0.
//  T5: en dropped after 9 samples for 3 cycles, then 16 x +1
//      -> sample_cnt=0 after the drop, avg_out=1; the partial 9 samples are discarded.
//  T6: rst=1 mid-block (cnt=11) with avg_valid=1 -> all outputs 0 next cycle.
//      The first block after reset needs a full 16 samples.

Source files
------------

// File: rtl/ds_adc_avg_decim.sv
// Block-mean decimator behind the delta-sigma ADC digital stage: sums 2**LOG2_N
// valid samples and presents the floored mean on a valid/ready port.
//
// state  | meaning
// IDLE   | disabled; acc and sample_cnt held at zero, pending result kept
// ACCUM  | accepting valid samples into the current block
module ds_adc_avg_decim #(
    parameter int WIDTH  = 8,
    parameter int LOG2_N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              din_valid,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  avg_out,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic              overrun,
    input  logic              clr_overrun,
    output logic [LOG2_N-1:0] sample_cnt
);

    localparam int ACC_W = WIDTH + LOG2_N;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  din_ext;
    logic [ACC_W-1:0]  acc_sum;
    logic [WIDTH-1:0]  result;
    logic              accept;
    logic              block_end;
    logic              xfer;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en)  state_d = S_ACCUM;
            S_ACCUM: if (!en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Leaving ACCUM takes priority over a sample presented on the same edge.
    assign accept    = (state_q == S_ACCUM) && en && din_valid;
    assign block_end = accept && (sample_cnt == {LOG2_N{1'b1}});
    assign din_ext   = {{LOG2_N{din[WIDTH-1]}}, din};
    assign acc_sum   = acc_q + din_ext;
    // Dropping the low LOG2_N bits of the two's-complement sum is a floor divide.
    assign result    = acc_sum[ACC_W-1:LOG2_N];
    assign xfer      = avg_valid && avg_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            sample_cnt <= '0;
        end else if (state_d == S_IDLE || block_end) begin
            acc_q      <= '0;
            sample_cnt <= '0;
        end else if (accept) begin
            acc_q      <= acc_sum;
            sample_cnt <= sample_cnt + LOG2_N'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            avg_out   <= '0;
            avg_valid <= 1'b0;
        end else if (block_end) begin
            avg_out   <= result;
            avg_valid <= 1'b1;
        end else if (xfer) begin
            avg_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (block_end && avg_valid && !avg_ready) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ds_adc_avg_decim.sv
// Directed bench for ds_adc_avg_decim: queue-based block model checked every cycle,
// plus literal expectations for each scenario.
module tb_ds_adc_avg_decim;

    localparam int WIDTH  = 8;
    localparam int LOG2_N = 4;
    localparam int N      = 1 << LOG2_N;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              din_valid = 1'b0;
    logic [WIDTH-1:0]  din = '0;
    logic [WIDTH-1:0]  avg_out;
    logic              avg_valid;
    logic              avg_ready = 1'b0;
    logic              overrun;
    logic              clr_overrun = 1'b0;
    logic [LOG2_N-1:0] sample_cnt;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    ds_adc_avg_decim #(.WIDTH(WIDTH), .LOG2_N(LOG2_N)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din_valid  (din_valid),
        .din        (din),
        .avg_out    (avg_out),
        .avg_valid  (avg_valid),
        .avg_ready  (avg_ready),
        .overrun    (overrun),
        .clr_overrun(clr_overrun),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the current block is a list of samples; a block ends when it holds N.
    int blk[$];
    bit m_on    = 1'b0;
    bit m_valid = 1'b0;
    bit m_ovr   = 1'b0;
    int m_out   = 0;

    function automatic int floor_div(input int s, input int d);
        if (s >= 0) return s / d;
        return -((-s + d - 1) / d);
    endfunction

    always @(posedge clk) begin
        bit new_res;
        int res;
        int sum;
        new_res = 1'b0;
        res     = 0;
        if (rst) begin
            blk.delete();
            m_on = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_out = 0;
        end else begin
            if (!m_on) begin
                if (en) m_on = 1'b1;
            end else if (!en) begin
                m_on = 1'b0;
                blk.delete();
            end else if (din_valid) begin
                blk.push_back(int'($signed(din)));
                if (blk.size() == N) begin
                    sum = 0;
                    foreach (blk[i]) sum += blk[i];
                    res = floor_div(sum, N);
                    new_res = 1'b1;
                    blk.delete();
                end
            end
            if (new_res && m_valid && !avg_ready) m_ovr = 1'b1;
            else if (clr_overrun)                 m_ovr = 1'b0;
            if (new_res) begin
                m_out = res; m_valid = 1'b1;
            end else if (m_valid && avg_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_avg_out",    int'($signed(avg_out)), m_out);
            chk("model_avg_valid",  int'(avg_valid),        int'(m_valid));
            chk("model_overrun",    int'(overrun),          int'(m_ovr));
            chk("model_sample_cnt", int'(sample_cnt),       blk.size());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int v, input int count);
        for (int i = 0; i < count; i++) begin
            din_valid = 1'b1;
            din = WIDTH'(v);
            step();
        end
        din_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input int v, input bit vld, input bit ovr);
        chk({name, "_avg_out"},   int'($signed(avg_out)), v);
        chk({name, "_avg_valid"}, int'(avg_valid),        int'(vld));
        chk({name, "_overrun"},   int'(overrun),          int'(ovr));
    endtask

    initial begin
        rst = 1'b1;
        step();
        chk_on = 1'b1;
        step();
        expect_out("reset", 0, 1'b0, 1'b0);
        chk("reset_cnt", int'(sample_cnt), 0);
        rst = 1'b0;

        // T1: entry-cycle sample ignored, a bubble mid-block, then a full block of +5.
        avg_ready = 1'b1;
        en = 1'b1; din_valid = 1'b1; din = 8'd99;
        step();
        din_valid = 1'b0;
        feed(5, 7);
        step();
        feed(5, 9);
        expect_out("t1", 5, 1'b1, 1'b0);
        chk("t1_cnt", int'(sample_cnt), 0);
        step();
        expect_out("t1_consumed", 5, 1'b0, 1'b0);

        // T2: floor toward -inf and the input range extremes.
        for (int i = 0; i < 8; i++) begin
            feed(3, 1);
            feed(-4, 1);
        end
        expect_out("t2_alt", -1, 1'b1, 1'b0);
        feed(-1, 16);
        expect_out("t2_m1", -1, 1'b1, 1'b0);
        feed(127, 16);
        expect_out("t2_max", 127, 1'b1, 1'b0);
        feed(-128, 16);
        expect_out("t2_min", -128, 1'b1, 1'b0);
        step();

        // T3: overwrite without consumption, clear, then set and clear on one edge.
        avg_ready = 1'b0;
        feed(2, 32);
        feed(7, 16);
        expect_out("t3", 7, 1'b1, 1'b1);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        expect_out("t3_clr", 7, 1'b1, 1'b0);
        feed(8, 15);
        clr_overrun = 1'b1;
        feed(8, 1);
        clr_overrun = 1'b0;
        expect_out("t3_set_wins", 8, 1'b1, 1'b1);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;

        // T4: result lands on the same edge the prior one is consumed.
        feed(4, 15);
        avg_ready = 1'b1;
        feed(4, 1);
        expect_out("t4", 4, 1'b1, 1'b0);
        step();
        expect_out("t4_consumed", 4, 1'b0, 1'b0);

        // T5: partial block discarded when en drops.
        feed(6, 9);
        chk("t5_partial_cnt", int'(sample_cnt), 9);
        en = 1'b0;
        step(); step(); step();
        chk("t5_drop_cnt", int'(sample_cnt), 0);
        en = 1'b1;
        step();
        feed(1, 16);
        expect_out("t5", 1, 1'b1, 1'b0);
        step();

        // T6: reset mid-block with a result pending.
        avg_ready = 1'b0;
        feed(9, 16);
        feed(9, 11);
        chk("t6_pre_cnt", int'(sample_cnt), 11);
        expect_out("t6_pre", 9, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_out("t6_rst", 0, 1'b0, 1'b0);
        chk("t6_rst_cnt", int'(sample_cnt), 0);
        step();
        feed(5, 15);
        chk("t6_cnt15", int'(sample_cnt), 15);
        chk("t6_not_yet", int'(avg_valid), 0);
        feed(5, 1);
        expect_out("t6_first", 5, 1'b1, 1'b0);
        step();

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
